// File: rtl/ebus_sequencer_if.sv
// EBOX request and EBUS signal bundle for the EBUS transaction sequencer.
// Data words are PDP-10 numbered: bit 0 is the MSB, held here in bit 35.
interface ebus_sequencer_if #(
    parameter int NDRV = 4
);
    logic                   start;
    logic [2:0]             reqFunc;
    logic [6:0]             reqCs;
    logic [35:0]            reqData;
    logic                   busy;
    logic                   done;
    logic                   tmo;
    logic [35:0]            rdData;
    logic [NDRV*36-1:0]     drvData;
    logic [NDRV-1:0]        drvDriving;
    logic [35:0]            ebusData;
    logic [6:0]             ebusCs;
    logic [2:0]             ebusFunc;
    logic                   ebusDemand;
    logic                   ebusAck;
    logic                   ebusXfer;
    logic                   contention;

    modport master (
        input  start, reqFunc, reqCs, reqData, drvData, drvDriving, ebusAck, ebusXfer,
        output busy, done, tmo, rdData, ebusData, ebusCs, ebusFunc, ebusDemand, contention
    );

    modport slave (
        output start, reqFunc, reqCs, reqData, drvData, drvDriving, ebusAck, ebusXfer,
        input  busy, done, tmo, rdData, ebusData, ebusCs, ebusFunc, ebusDemand, contention
    );
endinterface

// File: rtl/ebus_sequencer.sv
// EBOX-side EBUS sequencer: runs one demand/ack/xfer transaction at a time with timeouts,
// captures read data and ORs all driving sources onto EBUS data.
module ebus_sequencer #(
    parameter int NDRV      = 4,
    parameter int SETUP_CYC = 1,
    parameter int ACK_TMO   = 15
) (
    input  logic              clk,
    input  logic              resetN,
    ebus_sequencer_if.master  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_DEMAND  = 3'd2;
    localparam logic [2:0] S_XFER    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] ACK_LAST   = 8'(ACK_TMO - 1);

    logic [2:0]  r_state;
    logic [7:0]  r_cnt;
    logic [2:0]  r_func;
    logic [6:0]  r_cs;
    logic [35:0] r_data;
    logic [35:0] r_rd_data;
    logic        r_tmo;
    logic        r_done;
    logic        r_demand;

    logic [2:0]  w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic [7:0]  w_cnt_inc;
    logic        w_legal;
    logic        w_read;
    logic        w_write;
    logic        w_self;
    logic        w_accept;
    logic        w_timeout;
    logic        w_finish;
    logic        w_capture;
    logic        w_busy;
    logic [35:0] w_ebus_data;
    logic [7:0]  w_nsrc;

    assign w_legal   = (bus.reqFunc[2:1] != 2'b11);
    assign w_read    = (r_func == 3'b001) || (r_func == 3'b011) || (r_func == 3'b101);
    assign w_write   = (r_func == 3'b000) || (r_func == 3'b010);
    assign w_self    = w_write && ((r_state == S_DEMAND) || (r_state == S_XFER));
    assign w_busy    = (r_state != S_IDLE);
    assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // Wired-OR of every active source; the count only feeds the contention flag.
    always_comb begin
        w_ebus_data = '0;
        w_nsrc      = '0;
        for (int i = 0; i < NDRV; i++) begin
            if (bus.drvDriving[i]) begin
                w_ebus_data = w_ebus_data | bus.drvData[36*i +: 36];
                w_nsrc      = w_nsrc + 8'd1;
            end
        end
        if (w_self) begin
            w_ebus_data = w_ebus_data | r_data;
            w_nsrc      = w_nsrc + 8'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        w_timeout   = 1'b0;
        w_finish    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && w_legal) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = '0;
                    w_accept    = 1'b1;
                end
            end
            S_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt = S_DEMAND;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_DEMAND: begin
                if (bus.ebusAck) begin
                    w_state_nxt = S_XFER;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == ACK_LAST) begin
                    w_state_nxt = S_RELEASE;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_XFER: begin
                if (bus.ebusXfer) begin
                    w_state_nxt = S_RELEASE;
                    w_capture   = w_read;
                end else if (r_cnt == ACK_LAST) begin
                    w_state_nxt = S_RELEASE;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            S_RELEASE: begin
                // No timeout here: the device must drop ack/xfer before the next request.
                if (!bus.ebusAck && !bus.ebusXfer) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_finish    = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_func    <= '0;
            r_cs      <= '0;
            r_data    <= '0;
            r_rd_data <= '0;
            r_tmo     <= 1'b0;
            r_done    <= 1'b0;
            r_demand  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_done   <= w_finish;
            r_demand <= (w_state_nxt == S_DEMAND) || (w_state_nxt == S_XFER);
            if (w_accept) begin
                r_func <= bus.reqFunc;
                r_cs   <= bus.reqCs;
                r_data <= bus.reqData;
                r_tmo  <= 1'b0;
            end else if (w_timeout) begin
                r_tmo <= 1'b1;
            end
            if (w_capture) begin
                r_rd_data <= w_ebus_data;
            end
        end
    end

    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.tmo        = r_tmo;
    assign bus.rdData     = r_rd_data;
    assign bus.ebusData   = w_ebus_data;
    assign bus.ebusCs     = w_busy ? r_cs : 7'd0;
    assign bus.ebusFunc   = w_busy ? r_func : 3'd0;
    assign bus.ebusDemand = r_demand;
    assign bus.contention = (w_nsrc > 8'd1);
endmodule

// File: tb/tb_ebus_sequencer.sv
// Bench for ebus_sequencer: directed and randomized transactions against a cycle-schedule model.
module tb_ebus_sequencer;
    localparam int NDRV      = 4;
    localparam int SETUP_CYC = 1;
    localparam int ACK_TMO   = 15;
    localparam int NEVER     = 1 << 30;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    ebus_sequencer_if #(.NDRV(NDRV)) bus ();

    ebus_sequencer #(
        .NDRV      (NDRV),
        .SETUP_CYC (SETUP_CYC),
        .ACK_TMO   (ACK_TMO)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [35:0] exp_rd = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [35:0] rand36();
        return {4'($urandom), 32'($urandom)};
    endfunction

    function automatic logic [35:0] or_slots(input logic [NDRV-1:0] m,
                                             input logic [NDRV*36-1:0] s);
        logic [35:0] r = '0;
        for (int i = 0; i < NDRV; i++) if (m[i]) r = r | s[36*i +: 36];
        return r;
    endfunction

    task automatic device_off();
        bus.ebusAck    = 1'b0;
        bus.ebusXfer   = 1'b0;
        bus.drvDriving = '0;
    endtask

    // Expected timeline: SETUP from cycle 1, DEMAND from d0, release at r0, done at tdone.
    task automatic run_txn(input logic [2:0] func, input logic [6:0] cs, input logic [35:0] data,
                           input int ad, input int xd, input int hold,
                           input logic [NDRV-1:0] mask, input logic [NDRV*36-1:0] slots,
                           input bit noise);
        int d0, ta, x0, tx, cap, r0, tdrop, tdone;
        bit to, is_rd, is_wr, self_drv;
        logic [NDRV-1:0] act;
        logic [35:0] exp_data;
        d0    = 1 + SETUP_CYC;
        is_rd = (func == 3'b001) || (func == 3'b011) || (func == 3'b101);
        is_wr = (func == 3'b000) || (func == 3'b010);
        if (ad >= ACK_TMO) begin
            to = 1; ta = NEVER; tx = NEVER; r0 = d0 + ACK_TMO; tdrop = r0;
        end else begin
            ta = d0 + ad;
            x0 = ta + 1;
            if (xd >= ACK_TMO) begin
                to = 1; tx = NEVER; r0 = x0 + ACK_TMO;
            end else begin
                to  = 0;
                tx  = (xd < 0) ? ta : x0 + xd;
                cap = (xd < 0) ? x0 : tx;
                r0  = cap + 1;
            end
            tdrop = r0 + hold;
        end
        tdone = tdrop + 1;

        bus.start   = 1'b1;
        bus.reqFunc = func;
        bus.reqCs   = cs;
        bus.reqData = data;
        bus.drvData = slots;
        device_off();
        for (int t = 1; t <= tdone; t++) begin
            @(negedge clk);
            if (noise && t < tdone) begin
                bus.start   = 1'($urandom_range(1));
                bus.reqFunc = 3'($urandom_range(7));
                bus.reqCs   = 7'($urandom);
                bus.reqData = rand36();
            end else begin
                bus.start = 1'b0;
            end
            act            = (t >= tx && t < tdrop) ? mask : '0;
            bus.ebusAck    = (t >= ta && t < tdrop);
            bus.ebusXfer   = (t >= tx && t < tdrop);
            bus.drvDriving = act;
            #1;
            self_drv = is_wr && t >= d0 && t < r0;
            exp_data = or_slots(act, slots) | (self_drv ? data : 36'd0);
            chk("busy", 64'(bus.busy), 64'(t < tdone));
            chk("done", 64'(bus.done), 64'(t == tdone));
            chk("demand", 64'(bus.ebusDemand), 64'(t >= d0 && t < r0));
            chk("ebus_cs", 64'(bus.ebusCs), 64'((t < tdone) ? cs : 7'd0));
            chk("ebus_func", 64'(bus.ebusFunc), 64'((t < tdone) ? func : 3'd0));
            chk("ebus_data", 64'(bus.ebusData), 64'(exp_data));
            chk("contention", 64'(bus.contention),
                64'(($countones(act) + int'(self_drv)) > 1));
            if (t == 1) begin
                chk("tmo_clear", 64'(bus.tmo), 64'd0);
                chk("rd_hold", 64'(bus.rdData), 64'(exp_rd));
            end
            if (t == tdone) begin
                if (is_rd && !to) exp_rd = or_slots(mask, slots);
                chk("rd_data", 64'(bus.rdData), 64'(exp_rd));
                chk("tmo", 64'(bus.tmo), 64'(to));
            end
        end
    endtask

    task automatic idle_cycle(input bit illegal);
        bus.start   = illegal;
        bus.reqFunc = {2'b11, 1'($urandom)};
        bus.reqCs   = 7'($urandom);
        device_off();
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_done", 64'(bus.done), 64'd0);
        chk("idle_demand", 64'(bus.ebusDemand), 64'd0);
        chk("idle_cs", 64'(bus.ebusCs), 64'd0);
        chk("idle_func", 64'(bus.ebusFunc), 64'd0);
        chk("idle_data", 64'(bus.ebusData), 64'd0);
        chk("idle_contention", 64'(bus.contention), 64'd0);
        chk("idle_rd", 64'(bus.rdData), 64'(exp_rd));
    endtask

    logic [NDRV*36-1:0] slots;
    logic [2:0]         rfunc;
    int                 rad, rxd;

    initial begin
        bus.start   = 1'b0;
        bus.reqFunc = '0;
        bus.reqCs   = '0;
        bus.reqData = '0;
        bus.drvData = '0;
        device_off();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_tmo", 64'(bus.tmo), 64'd0);
        chk("rst_demand", 64'(bus.ebusDemand), 64'd0);
        chk("rst_rd", 64'(bus.rdData), 64'd0);
        chk("rst_cs", 64'(bus.ebusCs), 64'd0);
        chk("rst_func", 64'(bus.ebusFunc), 64'd0);
        resetN = 1'b1;
        idle_cycle(1'b0);

        // DATAI from slot 1, ack two cycles into DEMAND, xfer one cycle later
        slots = '0;
        slots[36 +: 36] = 36'o123456701234;
        run_txn(3'b011, 7'o14, 36'd0, 2, 0, 0, 4'b0010, slots, 1'b0);
        idle_cycle(1'b0);
        // CONO with an instant device
        run_txn(3'b000, 7'o02, 36'o777000000001, 0, 0, 0, 4'b0000, slots, 1'b0);
        idle_cycle(1'b0);
        // CONI never acknowledged, then a back-to-back start clears tmo
        run_txn(3'b001, 7'o03, 36'd0, ACK_TMO, 0, 0, 4'b0000, slots, 1'b0);
        slots = {rand36(), rand36(), rand36(), rand36()};
        run_txn(3'b011, 7'o04, 36'd0, 1, 1, 0, 4'b0101, slots, 1'b0);
        idle_cycle(1'b1);
        run_txn(3'b010, 7'o05, rand36(), 0, 0, 0, 4'b0001, slots, 1'b0);
        // Ack held five cycles after xfer, starts thrown at the busy sequencer
        run_txn(3'b101, 7'o06, 36'd0, 1, -1, 5, 4'b1000, slots, 1'b1);
        idle_cycle(1'b1);

        for (int n = 0; n < 30; n++) begin
            rfunc = 3'($urandom_range(5));
            rad   = ($urandom_range(5) == 0) ? ACK_TMO + int'($urandom_range(2))
                                             : int'($urandom_range(4));
            rxd   = ($urandom_range(7) == 0) ? ACK_TMO : int'($urandom_range(5)) - 1;
            slots = {rand36(), rand36(), rand36(), rand36()};
            run_txn(rfunc, 7'($urandom), rand36(), rad, rxd, int'($urandom_range(5)),
                    4'($urandom), slots, 1'($urandom));
            if ($urandom_range(1) == 1) idle_cycle(1'($urandom));
        end

        // Reset while in XFER: everything clears at once, no done pulse follows
        bus.start   = 1'b1;
        bus.reqFunc = 3'b011;
        bus.reqCs   = 7'o55;
        device_off();
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            bus.start   = 1'b0;
            bus.ebusAck = (t >= 2);
        end
        #1;
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        resetN = 1'b0;
        device_off();
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        chk("arst_tmo", 64'(bus.tmo), 64'd0);
        chk("arst_demand", 64'(bus.ebusDemand), 64'd0);
        chk("arst_rd", 64'(bus.rdData), 64'd0);
        chk("arst_cs", 64'(bus.ebusCs), 64'd0);
        chk("arst_func", 64'(bus.ebusFunc), 64'd0);
        exp_rd = '0;
        @(negedge clk);
        resetN = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            #1;
            chk("post_rst_done", 64'(bus.done), 64'd0);
            chk("post_rst_busy", 64'(bus.busy), 64'd0);
        end
        run_txn(3'b010, 7'o21, rand36(), 1, 0, 1, 4'b0000, slots, 1'b0);
        idle_cycle(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
